ar_stack_ctrl: RTL and testbench

- Sequencing controller for the 5-bit address register (AR) and the 32-entry memory it addresses. Together they form a hardware stack.
- Arbitrates between a push requester and a pop requester, and drives AR's 4-bit state code:
  - 0 = clear
  - 6 = increment
  - 8 = decrement
  - any other code = hold
- Drives memory write/read strobes and keeps a shadow occupancy count for the full/empty flags.
- Sits between the front-end request logic and the AR + memory datapath.

---
 rtl/ar_pkg.sv | 13 +
 rtl/rr_arb2.sv | 21 ++
 rtl/ar_stack_ctrl.sv | 62 ++++++
 tb/tb_ar_stack_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ar_pkg.sv
// ar_pkg: AR state codes and stack sizing shared by the controller and the AR datapath
package ar_pkg;
  localparam int AW = 5;
  localparam int DEPTH = 2 ** AW;
  localparam int CW = AW + 1;
  localparam logic [3:0] CLR      = 4'd0;
  localparam logic [3:0] IDLE     = 4'd1;
  localparam logic [3:0] PUSH_WR  = 4'd5;
  localparam logic [3:0] PUSH_INC = 4'd6;
  localparam logic [3:0] POP_DEC  = 4'd8;
  localparam logic [3:0] POP_RD   = 4'd9;
  localparam logic [3:0] DONE     = 4'd10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; requester a wins the first tie after reset
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic gnt_a,
  output logic gnt_b
);
  logic last_b;
  // on a tie the requester not served last time wins
  always_comb begin
    gnt_a = req_a & (~req_b | last_b);
    gnt_b = req_b & (~req_a | ~last_b);
  end
  // remember who was served whenever a grant is actually taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_b <= 1'b1;
    else if (take & (gnt_a | gnt_b)) last_b <= gnt_b;
endmodule

// File: rtl/ar_stack_ctrl.sv
// ar_stack_ctrl: sequences AR state codes and memory strobes to run a 32-entry hardware stack
module ar_stack_ctrl
  import ar_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic          flush,
  output logic [3:0]    state,
  output logic          mem_we,
  output logic          mem_re,
  output logic          push_done,
  output logic          pop_done,
  output logic          push_err,
  output logic          pop_err,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy
);
  logic [3:0] nxt;
  logic sample, op_pop, gnt_push, gnt_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign busy = state != IDLE;
  assign sample = (state == IDLE) & ~flush;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (push_req & ~full),
    .req_b (pop_req & ~empty),
    .take  (sample),
    .gnt_a (gnt_push),
    .gnt_b (gnt_pop)
  );
  // strobes, acknowledges and next state decoded from the current code
  always_comb begin
    mem_we = state == PUSH_WR;
    mem_re = state == POP_RD;
    push_done = (state == DONE) & ~op_pop;
    pop_done = (state == DONE) & op_pop;
    push_err = sample & push_req & full;
    pop_err = sample & pop_req & empty;
    nxt = state == IDLE     ? (flush ? CLR : gnt_push ? PUSH_WR : gnt_pop ? POP_DEC : IDLE) :
          state == PUSH_WR  ? PUSH_INC :
          state == PUSH_INC ? DONE :
          state == POP_DEC  ? POP_RD :
          state == POP_RD   ? DONE : IDLE;
  end
  // code register, shadow occupancy and the flag telling DONE which side to acknowledge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLR;
      count <= '0;
      op_pop <= 1'b0;
    end else begin
      state <= nxt;
      count <= state == CLR ? '0 : state == PUSH_INC ? count + CW'(1) : state == POP_DEC ? count - CW'(1) : count;
      if (sample & (gnt_push | gnt_pop)) op_pop <= gnt_pop;
    end
endmodule

// File: tb/tb_ar_stack_ctrl.sv
// tb_ar_stack_ctrl: vector table, corner sequences and random traffic against a transaction-level stack model
module tb_ar_stack_ctrl;
  logic clk = 0, rst_n, push_req, pop_req, flush;
  logic [3:0] state;
  logic mem_we, mem_re, push_done, pop_done, push_err, pop_err, full, empty, busy;
  logic [5:0] count;
  logic [7:0] wdata, rdata;
  logic [4:0] ar;
  logic [7:0] mem [32];
  int checks = 0, passed = 0;
  int m_st, m_cnt, q[$];
  bit m_last_pop, m_op_pop, cur_r;
  logic [7:0] stk[$], exp_rd;
  bit s_pd, s_od, s_pe, s_oe;
  logic [5:0] s_cnt;

  typedef struct {
    bit r, p, o, f;
    logic [3:0] st;
    bit we, re, pd, od, pe, oe;
    int cnt;
  } vec_t;
  vec_t tv[12];

  ar_stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .push_req(push_req), .pop_req(pop_req), .flush(flush),
    .state(state), .mem_we(mem_we), .mem_re(mem_re), .push_done(push_done), .pop_done(pop_done),
    .push_err(push_err), .pop_err(pop_err), .count(count), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // AR register and memory reacting to the codes and strobes the controller drives
  always @(posedge clk) begin
    if (state == 4'd0) ar <= 5'd0;
    else if (state == 4'd6) ar <= ar + 5'd1;
    else if (state == 4'd8) ar <= ar - 5'd1;
    if (mem_we) mem[ar] <= wdata;
    if (mem_re) rdata <= mem[ar];
  end

  function automatic logic [18:0] bund(logic [3:0] st, logic we, re, pd, od, pe, oe, logic [5:0] c, logic fl, em, bz);
    return {st, we, re, pd, od, pe, oe, c, fl, em, bz};
  endfunction

  function automatic logic [18:0] dut_b();
    return bund(state, mem_we, mem_re, push_done, pop_done, push_err, pop_err, count, full, empty, busy);
  endfunction

  function automatic logic [18:0] model_b();
    bit smp = (m_st == 1) && !flush;
    return bund(4'(m_st), m_st == 5, m_st == 9, m_st == 10 && !m_op_pop, m_st == 10 && m_op_pop,
                smp && push_req && m_cnt == 32, smp && pop_req && m_cnt == 0, 6'(m_cnt),
                m_cnt == 32, m_cnt == 0, m_st != 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; q.delete(); stk.delete(); m_last_pop = 1; m_op_pop = 0;
  endtask

  // one clock of the stack at transaction level: each grant schedules its whole code sequence
  task automatic model_edge(input bit p, o, f);
    bit pok, ook, gp;
    if (m_st == 0) m_cnt = 0;
    if (m_st == 5) stk.push_back(wdata);
    if (m_st == 6) m_cnt++;
    if (m_st == 8) m_cnt--;
    if (m_st == 1) begin
      if (f) begin
        q = '{0};
        stk.delete();
      end else begin
        pok = p && m_cnt < 32;
        ook = o && m_cnt > 0;
        gp = pok && (!ook || m_last_pop);
        if (gp) begin
          q = '{5, 6, 10}; m_last_pop = 0; m_op_pop = 0;
        end else if (ook) begin
          q = '{8, 9, 10}; m_last_pop = 1; m_op_pop = 1; exp_rd = stk.pop_back();
        end
      end
    end
    m_st = q.size() > 0 ? q.pop_front() : 1;
  endtask

  task automatic drive(input bit r, p, o, f);
    rst_n = r; push_req = p; pop_req = o; flush = f; cur_r = r;
    wdata = 8'($urandom);
    #1;
    if (!r) model_reset();
    chk("model", dut_b(), model_b());
    if (r && m_st == 10 && m_op_pop) chk("pop_data", rdata, exp_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_r) model_edge(push_req, pop_req, flush);
    else model_reset();
    @(negedge clk);
  endtask

  task automatic run_op(input bit p, o, input string nm);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      drive(1, p, o, 0);
      seen = push_done | pop_done | push_err | pop_err;
      if (seen) begin
        s_pd = push_done; s_od = pop_done; s_pe = push_err; s_oe = pop_err; s_cnt = count;
      end
      tick();
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit found;
    rst_n = 0; push_req = 0; pop_req = 0; flush = 0; wdata = 0; cur_r = 0;
    model_reset();
    tv[0]  = '{0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 1, 0, 0, 4'd1,  0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 1, 0, 0, 4'd5,  1, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{1, 1, 0, 0, 4'd6,  0, 0, 0, 0, 0, 0, 0};
    tv[5]  = '{1, 1, 0, 0, 4'd10, 0, 0, 1, 0, 0, 0, 1};
    tv[6]  = '{1, 0, 1, 0, 4'd1,  0, 0, 0, 0, 0, 0, 1};
    tv[7]  = '{1, 0, 1, 0, 4'd8,  0, 0, 0, 0, 0, 0, 1};
    tv[8]  = '{1, 0, 1, 0, 4'd9,  0, 1, 0, 0, 0, 0, 0};
    tv[9]  = '{1, 0, 1, 0, 4'd10, 0, 0, 0, 1, 0, 0, 0};
    tv[10] = '{1, 0, 1, 0, 4'd1,  0, 0, 0, 0, 0, 1, 0};
    tv[11] = '{1, 0, 0, 0, 4'd1,  0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].r, tv[i].p, tv[i].o, tv[i].f);
      chk($sformatf("vec%0d", i), dut_b(),
          bund(tv[i].st, tv[i].we, tv[i].re, tv[i].pd, tv[i].od, tv[i].pe, tv[i].oe, 6'(tv[i].cnt),
               tv[i].cnt == 32, tv[i].cnt == 0, tv[i].st != 4'd1));
      if (i == 3) chk("push_addr", ar, 0);
      if (i == 6) chk("ar_after_push", ar, 1);
      if (i == 8) chk("pop_addr", ar, 0);
      tick();
    end
    for (int i = 0; i < 32; i++) run_op(1, 0, "fill");
    drive(1, 1, 0, 0);
    chk("full_flags", {full, empty, count}, {1'b1, 1'b0, 6'd32});
    chk("ar_wrap", ar, 0);
    chk("push_err", {push_err, mem_we, state}, {1'b1, 1'b0, 4'd1});
    tick();
    drive(1, 0, 0, 0);
    chk("full_hold", {state, count}, {4'd1, 6'd32});
    tick();
    for (int i = 0; i < 27; i++) run_op(0, 1, "drain");
    for (int k = 0; k < 4; k++) begin
      run_op(1, 1, "alt");
      chk($sformatf("alt%0d", k), {s_pd, s_od, s_cnt}, (k % 2 == 0) ? {2'b10, 6'd6} : {2'b01, 6'd5});
    end
    run_op(1, 0, "pre_flush");
    run_op(1, 0, "pre_flush");
    drive(1, 1, 1, 1);
    chk("flush_idle", {state, push_done, pop_done, push_err, pop_err, count}, {4'd1, 4'b0, 6'd7});
    tick();
    drive(1, 0, 0, 0);
    chk("flush_clr", {state, push_done, pop_done, push_err, pop_err}, {4'd0, 4'b0});
    tick();
    drive(1, 0, 0, 0);
    chk("flush_done", {state, count, ar}, {4'd1, 6'd0, 5'd0});
    tick();
    run_op(1, 0, "pre_rst");
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      drive(1, 1, 0, 0);
      if (state == 4'd6) found = 1;
      else tick();
    end
    if (!found) chk("push_inc_timeout", 0, 1);
    drive(0, 1, 0, 0);
    chk("rst_async", {state, count, push_done, mem_we, empty}, {4'd0, 6'd0, 3'b001});
    tick();
    drive(1, 0, 0, 0);
    chk("rst_clr", {state, push_done}, {4'd0, 1'b0});
    tick();
    drive(1, 0, 0, 0);
    chk("rst_idle", {state, push_done}, {4'd1, 1'b0});
    tick();
    for (int i = 0; i < 2000; i++) begin
      int bias;
      bias = (i % 500 < 300) ? 8 : 3;
      drive($urandom_range(0, 399) != 0, $urandom_range(0, 9) < bias, $urandom_range(0, 9) < 11 - bias,
            $urandom_range(0, 79) == 0);
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
